// File: rtl/ekf_stage_sched.sv
// ekf_stage_sched: issues EKF-SLAM datapath stages one at a time.
//   Odometry frame -> PRD. New observation -> NEW. Re-observation -> UPD,
//   preceded by ASSOC when the build defines EKF_ASSOC_EN.
//   Each stage code is held on stage_val_o for STAGE_PULSE cycles. The
//   scheduler then waits for stage_rdy_i to echo the code. A watchdog
//   abandons the frame if no echo arrives.
//   The scheduler owns the landmark count and the active landmark index.
// Optional feature macro: EKF_ASSOC_EN (ASSOC stage before UPD on re-observation).
module ekf_stage_sched #(
    parameter int RSA_DW      = 32,
    parameter int RSA_AW      = 17,
    parameter int ROW_LEN     = 10,
    parameter int MAX_LM      = 64,
    parameter int STAGE_PULSE = 2,
    parameter int TMO_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 sys_rst_i,
    input  logic                 odo_val_i,
    output logic                 odo_rdy_o,
    input  logic [RSA_DW-1:0]    odo_vlr_i,
    input  logic [RSA_AW-1:0]    odo_alpha_i,
    input  logic                 obs_val_i,
    output logic                 obs_rdy_o,
    input  logic                 obs_new_i,
    input  logic [ROW_LEN-1:0]   obs_id_i,
    input  logic [RSA_DW-1:0]    obs_rk_i,
    input  logic [RSA_AW-1:0]    obs_phi_i,
    output logic [2:0]           stage_val_o,
    input  logic [2:0]           stage_rdy_i,
    output logic [ROW_LEN-1:0]   landmark_num_o,
    output logic [ROW_LEN-1:0]   l_k_o,
    output logic [RSA_DW-1:0]    vlr_o,
    output logic [RSA_AW-1:0]    alpha_o,
    output logic [RSA_DW-1:0]    rk_o,
    output logic [RSA_AW-1:0]    phi_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_full_o,
    output logic                 err_tmo_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] STG_IDLE  = 3'b000;
    localparam logic [2:0] STG_PRD   = 3'b001;
    localparam logic [2:0] STG_NEW   = 3'b010;
    localparam logic [2:0] STG_UPD   = 3'b011;
    localparam logic [2:0] STG_ASSOC = 3'b100;

`ifdef EKF_ASSOC_EN
    // Re-observations start with data association; UPD follows on completion.
    localparam logic [2:0] STG_REOBS = STG_ASSOC;
`else
    localparam logic [2:0] STG_REOBS = STG_UPD;
`endif

    localparam logic [ROW_LEN-1:0] MAX_LM_C   = ROW_LEN'(MAX_LM);
    localparam logic [ROW_LEN-1:0] LM_ONE     = {{(ROW_LEN-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_ONE    = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_LIMIT  = {TMO_W{1'b1}};
    localparam logic [2:0]         PULSE_LAST = 3'(STAGE_PULSE - 1);

    state_t               state_q;
    logic [2:0]           cur_stage_q;
    logic [2:0]           stage_val_q;
    logic [2:0]           pulse_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [ROW_LEN-1:0]   landmark_num_q;
    logic [ROW_LEN-1:0]   l_k_q;
    logic [RSA_DW-1:0]    vlr_q;
    logic [RSA_AW-1:0]    alpha_q;
    logic [RSA_DW-1:0]    rk_q;
    logic [RSA_AW-1:0]    phi_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_full_q;
    logic                 err_tmo_q;

    logic                 odo_fire_s;
    logic                 obs_fire_s;
    logic                 obs_refuse_s;
    logic [2:0]           obs_stage_s;
    logic [ROW_LEN-1:0]   obs_lk_s;
    logic [TMO_W-1:0]     tmo_d;

    // rdy_q is high exactly when the scheduler sits in IDLE outside reset.
    // Odometry wins a same-cycle tie with an observation.
    assign odo_rdy_o  = rdy_q;
    assign obs_rdy_o  = rdy_q & ~odo_val_i;
    assign odo_fire_s = odo_val_i & rdy_q;
    assign obs_fire_s = obs_val_i & rdy_q & ~odo_val_i;

    // A new landmark needs a free map slot; a re-observation needs an existing index.
    assign obs_refuse_s = obs_new_i ? (landmark_num_q >= MAX_LM_C)
                                    : (obs_id_i >= landmark_num_q);
    assign obs_stage_s  = obs_new_i ? STG_NEW : STG_REOBS;
    assign obs_lk_s     = obs_new_i ? landmark_num_q : obs_id_i;
    assign tmo_d        = tmo_q + TMO_ONE;

    assign stage_val_o    = stage_val_q;
    assign landmark_num_o = landmark_num_q;
    assign l_k_o          = l_k_q;
    assign vlr_o          = vlr_q;
    assign alpha_o        = alpha_q;
    assign rk_o           = rk_q;
    assign phi_o          = phi_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_full_o     = err_full_q;
    assign err_tmo_o      = err_tmo_q;

    // Stage sequencer: frame acceptance, stage issue pulse, completion wait, watchdog.
    always_ff @(posedge clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q        <= ST_IDLE;
            cur_stage_q    <= STG_IDLE;
            stage_val_q    <= STG_IDLE;
            pulse_q        <= 3'd0;
            tmo_q          <= {TMO_W{1'b0}};
            landmark_num_q <= {ROW_LEN{1'b0}};
            l_k_q          <= {ROW_LEN{1'b0}};
            vlr_q          <= {RSA_DW{1'b0}};
            alpha_q        <= {RSA_AW{1'b0}};
            rk_q           <= {RSA_DW{1'b0}};
            phi_q          <= {RSA_AW{1'b0}};
            rdy_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_full_q     <= 1'b0;
            err_tmo_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_full_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (odo_fire_s) begin
                        vlr_q       <= odo_vlr_i;
                        alpha_q     <= odo_alpha_i;
                        cur_stage_q <= STG_PRD;
                        stage_val_q <= STG_PRD;
                        pulse_q     <= 3'd0;
                        tmo_q       <= {TMO_W{1'b0}};
                        state_q     <= ST_ISSUE;
                        rdy_q       <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (obs_fire_s) begin
                        rk_q  <= obs_rk_i;
                        phi_q <= obs_phi_i;
                        if (obs_refuse_s) begin
                            // Frame is consumed but nothing runs; stay ready.
                            err_full_q <= 1'b1;
                            rdy_q      <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            l_k_q       <= obs_lk_s;
                            cur_stage_q <= obs_stage_s;
                            stage_val_q <= obs_stage_s;
                            pulse_q     <= 3'd0;
                            tmo_q       <= {TMO_W{1'b0}};
                            state_q     <= ST_ISSUE;
                            rdy_q       <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else begin
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // stage_rdy_i is deliberately not looked at until the pulse is over.
                    if (pulse_q == PULSE_LAST) begin
                        stage_val_q <= STG_IDLE;
                        tmo_q       <= {TMO_W{1'b0}};
                        state_q     <= ST_WAIT;
                    end else begin
                        pulse_q <= pulse_q + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (stage_rdy_i == cur_stage_q) begin
                        if (cur_stage_q == STG_NEW) begin
                            landmark_num_q <= landmark_num_q + LM_ONE;
                        end else begin
                            landmark_num_q <= landmark_num_q;
                        end
                        if (cur_stage_q == STG_ASSOC) begin
                            // Association done: chain straight into UPD on the same l_k.
                            cur_stage_q <= STG_UPD;
                            stage_val_q <= STG_UPD;
                            pulse_q     <= 3'd0;
                            tmo_q       <= {TMO_W{1'b0}};
                            state_q     <= ST_ISSUE;
                        end else begin
                            cur_stage_q <= STG_IDLE;
                            done_q      <= 1'b1;
                            state_q     <= ST_IDLE;
                            rdy_q       <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else if (tmo_d == TMO_LIMIT) begin
                        // Top never answered: drop the frame, map untouched.
                        cur_stage_q <= STG_IDLE;
                        err_tmo_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                        rdy_q       <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cur_stage_q <= STG_IDLE;
                    stage_val_q <= STG_IDLE;
                    rdy_q       <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Scoreboard bench for ekf_stage_sched (small map and short watchdog).
module tb_ekf_stage_sched;

    localparam int RSA_DW      = 32;
    localparam int RSA_AW      = 17;
    localparam int ROW_LEN     = 10;
    localparam int MAX_LM      = 4;
    localparam int STAGE_PULSE = 2;
    localparam int TMO_W       = 4;

    localparam logic [2:0] S_PRD   = 3'b001;
    localparam logic [2:0] S_NEW   = 3'b010;
    localparam logic [2:0] S_UPD   = 3'b011;
    localparam logic [2:0] S_ASSOC = 3'b100;

    localparam int EV_STAGE = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_FULL  = 3;
    localparam int EV_TMO   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 odo_val, odo_rdy, obs_val, obs_rdy, obs_new;
    logic [RSA_DW-1:0]    odo_vlr, obs_rk, vlr, rk;
    logic [RSA_AW-1:0]    odo_alpha, obs_phi, alpha, phi;
    logic [ROW_LEN-1:0]   obs_id, landmark_num, l_k;
    logic [2:0]           stage_val, stage_rdy;
    logic                 busy, done, err_full, err_tmo;

    always #5 clk = ~clk;

    ekf_stage_sched #(
        .RSA_DW(RSA_DW), .RSA_AW(RSA_AW), .ROW_LEN(ROW_LEN),
        .MAX_LM(MAX_LM), .STAGE_PULSE(STAGE_PULSE), .TMO_W(TMO_W)
    ) dut (
        .clk_i(clk), .sys_rst_i(rst),
        .odo_val_i(odo_val), .odo_rdy_o(odo_rdy), .odo_vlr_i(odo_vlr), .odo_alpha_i(odo_alpha),
        .obs_val_i(obs_val), .obs_rdy_o(obs_rdy), .obs_new_i(obs_new), .obs_id_i(obs_id),
        .obs_rk_i(obs_rk), .obs_phi_i(obs_phi),
        .stage_val_o(stage_val), .stage_rdy_i(stage_rdy),
        .landmark_num_o(landmark_num), .l_k_o(l_k),
        .vlr_o(vlr), .alpha_o(alpha), .rk_o(rk), .phi_o(phi),
        .busy_o(busy), .done_o(done), .err_full_o(err_full), .err_tmo_o(err_tmo)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_err = 0;
    int         n_chk = 0;
    int         lm_m  = 0;
    int         lk_m  = 0;
    logic [2:0] prev_sv = 3'b000;
    int         run_len = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int stage_ev(input int lk, input logic [2:0] code);
        return (lk << 3) | int'(code);
    endfunction

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_event_kind", kind, e.kind);
            check_eq("sb_event_val", val, e.val);
        end
    endtask

    // Per-cycle observation of DUT outputs, called 1 time unit after each rising edge.
    task automatic monitor();
        if (rst) begin
            prev_sv = 3'b000;
            run_len = 0;
        end else begin
            if (stage_val != 3'b000 && prev_sv == 3'b000)
                got_ev(EV_STAGE, stage_ev(int'(l_k), stage_val));
            if (stage_val != 3'b000) begin
                run_len++;
            end else if (prev_sv != 3'b000) begin
                check_eq("pulse_len", run_len, STAGE_PULSE);
                run_len = 0;
            end
            if (done)     got_ev(EV_DONE, int'(landmark_num));
            if (err_full) got_ev(EV_FULL, 0);
            if (err_tmo)  got_ev(EV_TMO, int'(landmark_num));
            prev_sv = stage_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic send_odo(input logic [RSA_DW-1:0] v, input logic [RSA_AW-1:0] a);
        int n = 0;
        odo_vlr   = v;
        odo_alpha = a;
        odo_val   = 1'b1;
        while (!odo_rdy && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("odo_rdy_timeout", odo_rdy, 1);
        tick();
        odo_val = 1'b0;
    endtask

    task automatic send_obs(input logic nw, input int id, input logic [RSA_DW-1:0] r, input logic [RSA_AW-1:0] p);
        int n = 0;
        obs_new = nw;
        obs_id  = ROW_LEN'(id);
        obs_rk  = r;
        obs_phi = p;
        obs_val = 1'b1;
        while (!obs_rdy && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("obs_rdy_timeout", obs_rdy, 1);
        tick();
        obs_val = 1'b0;
    endtask

    // mode 0: plain echo; 1: echo during ISSUE first (must be ignored); 2: wrong code first.
    task automatic run_stage(input logic [2:0] code, input int mode);
        int n = 0;
        while (stage_val !== code && n < 40) begin tick(); n++; end
        if (n >= 40) check_eq("stage_wait_timeout", stage_val, code);
        if (mode == 1) begin
            stage_rdy = code;
            tick();
            stage_rdy = 3'b000;
        end
        n = 0;
        while (stage_val !== 3'b000 && n < 20) begin tick(); n++; end
        if (mode == 2) begin
            stage_rdy = (code == S_PRD) ? S_NEW : S_PRD;
            tick();
        end
        stage_rdy = code;
        tick();
        stage_rdy = 3'b000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin tick(); n++; end
        if (n >= 60) check_eq("idle_timeout", busy, 0);
        tick();
    endtask

    task automatic odo_frame(input logic [RSA_DW-1:0] v, input logic [RSA_AW-1:0] a, input int mode);
        expect_ev(EV_STAGE, stage_ev(lk_m, S_PRD));
        expect_ev(EV_DONE, lm_m);
        send_odo(v, a);
        run_stage(S_PRD, mode);
        wait_idle();
    endtask

    task automatic obs_frame(input logic nw, input int id, input logic [RSA_DW-1:0] r,
                             input logic [RSA_AW-1:0] p, input int mode);
        if (nw) begin
            if (lm_m >= MAX_LM) begin
                expect_ev(EV_FULL, 0);
                send_obs(nw, id, r, p);
                check_eq("full_new_idle", busy, 0);
            end else begin
                lk_m = lm_m;
                expect_ev(EV_STAGE, stage_ev(lk_m, S_NEW));
                lm_m++;
                expect_ev(EV_DONE, lm_m);
                send_obs(nw, id, r, p);
                run_stage(S_NEW, mode);
            end
        end else begin
            if (id >= lm_m) begin
                expect_ev(EV_FULL, 0);
                send_obs(nw, id, r, p);
                check_eq("bad_id_idle", busy, 0);
            end else begin
                lk_m = id;
`ifdef EKF_ASSOC_EN
                expect_ev(EV_STAGE, stage_ev(lk_m, S_ASSOC));
`endif
                expect_ev(EV_STAGE, stage_ev(lk_m, S_UPD));
                expect_ev(EV_DONE, lm_m);
                send_obs(nw, id, r, p);
`ifdef EKF_ASSOC_EN
                run_stage(S_ASSOC, mode);
`endif
                run_stage(S_UPD, mode);
            end
        end
        wait_idle();
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1;
        odo_val = 1'b0; obs_val = 1'b0; obs_new = 1'b0; obs_id = '0;
        odo_vlr = '0; odo_alpha = '0; obs_rk = '0; obs_phi = '0; stage_rdy = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stage_val", stage_val, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_odo_rdy", odo_rdy, 0);
        check_eq("rst_landmark_num", landmark_num, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        tick();
        tick();
        check_eq("idle_odo_rdy", odo_rdy, 1);

        // Odometry frame: PRD only, operands latched
        expect_ev(EV_STAGE, stage_ev(lk_m, S_PRD));
        expect_ev(EV_DONE, lm_m);
        send_odo(32'h0010_0000, 17'h1_2345);
        check_eq("odo_busy", busy, 1);
        check_eq("odo_rdy_busy", odo_rdy, 0);
        check_eq("vlr_out", vlr, 32'h0010_0000);
        check_eq("alpha_out", alpha, 17'h1_2345);
        run_stage(S_PRD, 0);
        wait_idle();

        // Three new landmarks, with ignored echoes during ISSUE / wrong codes in WAIT
        obs_frame(1'b1, 0, 32'h0000_1111, 17'h0_0011, 0);
        obs_frame(1'b1, 0, 32'h0000_2222, 17'h0_0022, 1);
        obs_frame(1'b1, 0, 32'h0000_3333, 17'h0_0033, 2);
        check_eq("lm_after_3_new", landmark_num, 3);
        check_eq("rk_out", rk, 32'h0000_3333);

        // Odometry and observation in the same cycle: PRD first
        expect_ev(EV_STAGE, stage_ev(lk_m, S_PRD));
        expect_ev(EV_DONE, lm_m);
`ifdef EKF_ASSOC_EN
        expect_ev(EV_STAGE, stage_ev(1, S_ASSOC));
`endif
        expect_ev(EV_STAGE, stage_ev(1, S_UPD));
        expect_ev(EV_DONE, lm_m);
        odo_vlr = 32'hABCD_0001; odo_alpha = 17'h0_0777;
        obs_new = 1'b0; obs_id = 10'd1; obs_rk = 32'h5555_0000; obs_phi = 17'h1_0001;
        odo_val = 1'b1; obs_val = 1'b1;
        n = 0;
        while (!odo_rdy && n < 50) begin tick(); n++; end
        tick();
        odo_val = 1'b0;
        check_eq("tie_obs_rdy_low", obs_rdy, 0);
        check_eq("tie_rk_held", rk, 32'h0000_3333);
        check_eq("tie_vlr", vlr, 32'hABCD_0001);
        run_stage(S_PRD, 0);
        n = 0;
        while (!obs_rdy && n < 50) begin tick(); n++; end
        tick();
        obs_val = 1'b0;
        lk_m = 1;
        check_eq("tie_rk_latched", rk, 32'h5555_0000);
`ifdef EKF_ASSOC_EN
        run_stage(S_ASSOC, 0);
`endif
        run_stage(S_UPD, 0);
        wait_idle();
        check_eq("tie_vlr_hold", vlr, 32'hABCD_0001);

        // Watchdog on a NEW stage: no echo, map count unchanged
        lk_m = lm_m;
        expect_ev(EV_STAGE, stage_ev(lk_m, S_NEW));
        expect_ev(EV_TMO, lm_m);
        send_obs(1'b1, 0, 32'h0000_4444, 17'h0_0044);
        n = 0;
        while (stage_val !== 3'b000 && n < 20) begin tick(); n++; end
        k = 0;
        while (!err_tmo && k < 40) begin tick(); k++; end
        check_eq("tmo_wait_cycles", k, (1 << TMO_W) - 1);
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_lm", landmark_num, 3);
        wait_idle();

        // Fill the map, then refused frames and id bounds
        obs_frame(1'b1, 0, 32'h0000_6666, 17'h0_0066, 0);
        check_eq("lm_full", landmark_num, MAX_LM);
        obs_frame(1'b1, 0, 32'h0000_7777, 17'h0_0077, 0);
        obs_frame(1'b0, 5, 32'h0000_8888, 17'h0_0088, 0);
        obs_frame(1'b0, MAX_LM, 32'h0000_9999, 17'h0_0099, 0);
        obs_frame(1'b0, MAX_LM - 1, 32'h0000_AAAA, 17'h0_00AA, 2);
        check_eq("lm_after_refusals", landmark_num, MAX_LM);
        check_eq("lk_last_upd", l_k, MAX_LM - 1);

        // Reset in the middle of a WAIT
        expect_ev(EV_STAGE, stage_ev(lk_m, S_PRD));
        send_odo(32'h1234_5678, 17'h0_0ABC);
        n = 0;
        while (stage_val !== 3'b000 && n < 20) begin tick(); n++; end
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_lm", landmark_num, 0);
        check_eq("mid_rst_vlr", vlr, 0);
        check_eq("mid_rst_lk", l_k, 0);
        check_eq("mid_rst_done", done, 0);
        tick();
        rst = 1'b0;
        lm_m = 0;
        lk_m = 0;
        tick();
        obs_frame(1'b1, 0, 32'h0000_BBBB, 17'h0_00BB, 0);
        check_eq("post_rst_lm", landmark_num, 1);

        tick(); tick();
        check_eq("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
